// File: rtl/sms_power_seq_if.sv
// rtl/sms_power_seq_if.sv - console keys, interlock, card resets and lamps of the power sequencer
//
// Purpose: groups the sequencer's console/card-side signals into one bundle.
// Ports (signals):
//   power_on_key, power_off_key  console keys, synchronous levels
//   thermal_ok                   thermal interlock, 1 = OK
//   stage_rst_n[N_STAGES]        per-group card reset, 0 = held in reset
//   ready                        all stages released
//   ind_power, ind_fault         indicator lamps
//   state[3]                     encoded sequencer state
// Modports: master = console/card side, slave = sequencer.

interface sms_power_seq_if #(
    parameter int N_STAGES = 4
);
    logic                power_on_key;
    logic                power_off_key;
    logic                thermal_ok;
    logic [N_STAGES-1:0] stage_rst_n;
    logic                ready;
    logic                ind_power;
    logic                ind_fault;
    logic [2:0]          state;

    modport master (
        output power_on_key,
        output power_off_key,
        output thermal_ok,
        input  stage_rst_n,
        input  ready,
        input  ind_power,
        input  ind_fault,
        input  state
    );

    modport slave (
        input  power_on_key,
        input  power_off_key,
        input  thermal_ok,
        output stage_rst_n,
        output ready,
        output ind_power,
        output ind_fault,
        output state
    );
endinterface

// File: rtl/sms_power_seq.sv
// rtl/sms_power_seq.sv - card-group power-on/off reset sequencer with thermal interlock
//
// Purpose: releases the card-group resets one by one after POWER ON, re-asserts
// them in reverse order after POWER OFF, and drops every group into reset at once
// when the thermal interlock opens.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   sms_power_seq_if.slave: keys, interlock, stage resets, ready, lamps, state

module sms_power_seq #(
    parameter int N_STAGES    = 4,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic           clk,
    input  logic           rst,
    sms_power_seq_if.slave bus
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam int SW = $clog2(N_STAGES + 1);

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_RAMP     = 3'd1,
        ST_READY    = 3'd2,
        ST_SHUTDOWN = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    state_t              state_q, state_n;
    logic [CW-1:0]       cnt_q, cnt_n;
    logic [SW-1:0]       rel_q, rel_n;      // number of stages currently released
    logic [N_STAGES-1:0] stage_q, stage_n;
    logic                ready_q, ready_n;
    logic                pwr_q, pwr_n;
    logic                flt_q, flt_n;

    logic                on_prev, off_prev;
    logic                on_armed, off_armed;
    logic                on_edge, off_edge;
    logic                expiry;
    logic                active;

    // Key edge detection. The armed flags stay clear after reset until the key
    // has been seen low, so a key held through reset produces no edge. Edges are
    // registered, giving the FSM one cycle of latency from the sampled press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            on_prev   <= 1'b0;
            off_prev  <= 1'b0;
            on_armed  <= 1'b0;
            off_armed <= 1'b0;
            on_edge   <= 1'b0;
            off_edge  <= 1'b0;
        end else begin
            on_prev   <= bus.power_on_key;
            off_prev  <= bus.power_off_key;
            on_armed  <= on_armed | ~bus.power_on_key;
            off_armed <= off_armed | ~bus.power_off_key;
            on_edge   <= bus.power_on_key & ~on_prev & on_armed;
            off_edge  <= bus.power_off_key & ~off_prev & off_armed;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            rel_q   <= '0;
            stage_q <= '0;
            ready_q <= 1'b0;
            pwr_q   <= 1'b0;
            flt_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            rel_q   <= rel_n;
            stage_q <= stage_n;
            ready_q <= ready_n;
            pwr_q   <= pwr_n;
            flt_q   <= flt_n;
        end
    end

    assign expiry = (cnt_q == CW'(HOLD_CYCLES - 1));
    assign active = (state_q == ST_RAMP) || (state_q == ST_READY) || (state_q == ST_SHUTDOWN);

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        rel_n   = rel_q;

        if (active && !bus.thermal_ok) begin
            // Interlock wins over everything: all groups back into reset together.
            state_n = ST_FAULT;
            cnt_n   = '0;
            rel_n   = '0;
        end else if (off_edge && (state_q == ST_RAMP || state_q == ST_READY)) begin
            state_n = ST_SHUTDOWN;
            cnt_n   = '0;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    if (on_edge && bus.thermal_ok) begin
                        state_n = ST_RAMP;
                        cnt_n   = '0;
                    end
                end
                ST_RAMP: begin
                    if (expiry) begin
                        cnt_n = '0;
                        rel_n = rel_q + SW'(1);
                        if (rel_q == SW'(N_STAGES - 1)) begin
                            state_n = ST_READY;
                        end
                    end else begin
                        cnt_n = cnt_q + CW'(1);
                    end
                end
                ST_READY: begin
                    cnt_n = '0;
                end
                ST_SHUTDOWN: begin
                    if (rel_q == '0) begin
                        // Entered before any release: nothing to sequence down.
                        state_n = ST_OFF;
                        cnt_n   = '0;
                    end else if (expiry) begin
                        cnt_n = '0;
                        rel_n = rel_q - SW'(1);
                        if (rel_q == SW'(1)) begin
                            state_n = ST_OFF;
                        end
                    end else begin
                        cnt_n = cnt_q + CW'(1);
                    end
                end
                ST_FAULT: begin
                    if (off_edge && bus.thermal_ok) begin
                        state_n = ST_OFF;
                        cnt_n   = '0;
                    end
                end
                default: begin
                    state_n = ST_OFF;
                    cnt_n   = '0;
                    rel_n   = '0;
                end
            endcase
        end

        // Registered outputs are computed from the next state so they change on
        // the same edge as the state they describe.
        stage_n = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            stage_n[i] = (SW'(i) < rel_n);
        end
        ready_n = (state_n == ST_READY);
        pwr_n   = (state_n == ST_RAMP) || (state_n == ST_READY) || (state_n == ST_SHUTDOWN);
        flt_n   = (state_n == ST_FAULT);
    end

    assign bus.stage_rst_n = stage_q;
    assign bus.ready       = ready_q;
    assign bus.ind_power   = pwr_q;
    assign bus.ind_fault   = flt_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_sms_power_seq.sv
// tb/tb_sms_power_seq.sv - self-checking bench for sms_power_seq

module tb_sms_power_seq;

    localparam int N = 4;
    localparam int H = 5;

    localparam int M_OFF = 0, M_RAMP = 1, M_READY = 2, M_SHUT = 3, M_FAULT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sms_power_seq_if #(.N_STAGES(N)) bus ();

    sms_power_seq #(.N_STAGES(N), .HOLD_CYCLES(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: event deadlines in absolute edge numbers.
    int m_state, m_rel, m_due;
    bit m_on_last, m_on_low, m_on_pend;
    bit m_off_last, m_off_low, m_off_pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_OFF; m_rel = 0; m_due = 0;
        m_on_last = 0; m_on_low = 0; m_on_pend = 0;
        m_off_last = 0; m_off_low = 0; m_off_pend = 0;
    endtask

    task automatic model_step();
        bit on_ev, off_ev, on, off, th;
        on = bus.power_on_key; off = bus.power_off_key; th = bus.thermal_ok;
        on_ev = m_on_pend; off_ev = m_off_pend;
        m_on_pend  = on && !m_on_last && m_on_low;
        m_on_low   = m_on_low || !on;
        m_on_last  = on;
        m_off_pend = off && !m_off_last && m_off_low;
        m_off_low  = m_off_low || !off;
        m_off_last = off;

        if ((m_state == M_RAMP || m_state == M_READY || m_state == M_SHUT) && !th) begin
            m_state = M_FAULT; m_rel = 0;
        end else if (off_ev && (m_state == M_RAMP || m_state == M_READY)) begin
            m_state = M_SHUT;
            m_due = (m_rel == 0) ? cyc + 1 : cyc + H;
        end else if (m_state == M_FAULT) begin
            if (off_ev && th) m_state = M_OFF;
        end else if (m_state == M_OFF) begin
            if (on_ev && th) begin
                m_state = M_RAMP; m_due = cyc + H;
            end
        end else if (m_state == M_RAMP && cyc == m_due) begin
            m_rel++;
            if (m_rel == N) m_state = M_READY;
            else m_due += H;
        end else if (m_state == M_SHUT && cyc == m_due) begin
            if (m_rel > 0) m_rel--;
            if (m_rel == 0) m_state = M_OFF;
            else m_due += H;
        end
    endtask

    task automatic check_all();
        check("state", 32'(bus.state), 32'(m_state));
        check("stage_rst_n", 32'(bus.stage_rst_n), (32'd1 << m_rel) - 32'd1);
        check("ready", 32'(bus.ready), 32'(m_state == M_READY));
        check("ind_power", 32'(bus.ind_power),
              32'(m_state == M_RAMP || m_state == M_READY || m_state == M_SHUT));
        check("ind_fault", 32'(bus.ind_fault), 32'(m_state == M_FAULT));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_on();
        bus.power_on_key = 1'b0; tick();
        bus.power_on_key = 1'b1; ticks(2);
    endtask

    initial begin
        model_reset();
        bus.power_on_key = 1'b0; bus.power_off_key = 1'b0; bus.thermal_ok = 1'b1;

        // Reset for 3 cycles
        ticks(3);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_stage", 32'(bus.stage_rst_n), 32'd0);
        check("rst_lamps", {29'd0, bus.ready, bus.ind_power, bus.ind_fault}, 32'd0);
        rst = 1'b0;
        ticks(2);

        // Ramp: RAMP one edge after the sampled press, then a release every H edges
        bus.power_on_key = 1'b1; tick();
        check("ramp_latency", 32'(bus.state), 32'd0);
        tick();
        check("ramp_enter", 32'(bus.state), 32'd1);
        ticks(H); check("ramp_s0", 32'(bus.stage_rst_n), 32'b0001);
        ticks(H); check("ramp_s1", 32'(bus.stage_rst_n), 32'b0011);
        ticks(H); check("ramp_s2", 32'(bus.stage_rst_n), 32'b0111);
        ticks(H - 1); check("ramp_s3_early", 32'(bus.ready), 32'd0);
        tick();
        check("ramp_s3", 32'(bus.stage_rst_n), 32'b1111);
        check("ramp_ready", {29'd0, bus.ready, bus.ind_power, bus.ind_fault}, 32'b110);
        check("ramp_state", 32'(bus.state), 32'd2);
        ticks(4);

        // Shutdown from READY
        bus.power_off_key = 1'b1; ticks(2);
        check("shut_enter", {28'd0, bus.state, bus.ready}, {28'd0, 3'd3, 1'b0});
        ticks(H); check("shut_s3", 32'(bus.stage_rst_n), 32'b0111);
        ticks(H); check("shut_s2", 32'(bus.stage_rst_n), 32'b0011);
        ticks(H); check("shut_s1", 32'(bus.stage_rst_n), 32'b0001);
        ticks(H);
        check("shut_done", {27'd0, bus.state, bus.stage_rst_n[0], bus.ind_power}, 32'd0);
        bus.power_off_key = 1'b0; bus.power_on_key = 1'b0; ticks(2);

        // Shutdown mid-RAMP after two releases
        press_on(); ticks(2 * H);
        check("mid_pre", 32'(bus.stage_rst_n), 32'b0011);
        bus.power_off_key = 1'b1; ticks(2);
        ticks(H); check("mid_s1", 32'(bus.stage_rst_n), 32'b0001);
        ticks(H); check("mid_off", 32'(bus.state), 32'd0);
        bus.power_off_key = 1'b0; bus.power_on_key = 1'b0; ticks(2);

        // Shutdown before any release
        press_on(); bus.power_off_key = 1'b1; ticks(2);
        check("early_shut", 32'(bus.state), 32'd3);
        tick(); check("early_off", 32'(bus.state), 32'd0);
        bus.power_off_key = 1'b0; bus.power_on_key = 1'b0; ticks(2);

        // Fault from READY, then recovery
        press_on(); ticks(N * H);
        check("flt_pre", 32'(bus.state), 32'd2);
        bus.thermal_ok = 1'b0; tick();
        check("flt_enter", {26'd0, bus.state, bus.stage_rst_n[3], bus.ind_fault, bus.ind_power},
              {26'd0, 3'd4, 1'b0, 1'b1, 1'b0});
        press_on(); tick(); check("flt_on_ign", 32'(bus.state), 32'd4);
        bus.power_off_key = 1'b1; ticks(3); check("flt_off_hot", 32'(bus.state), 32'd4);
        bus.power_off_key = 1'b0; bus.thermal_ok = 1'b1; tick();
        bus.power_off_key = 1'b1; ticks(2);
        check("flt_clear", {28'd0, bus.state, bus.ind_fault}, 32'd0);
        bus.power_off_key = 1'b0; bus.power_on_key = 1'b0; ticks(2);

        // Both keys in the same cycle: OFF starts a ramp, RAMP shuts down
        bus.power_on_key = 1'b1; bus.power_off_key = 1'b1; ticks(2);
        check("both_off", 32'(bus.state), 32'd1);
        bus.power_on_key = 1'b0; bus.power_off_key = 1'b0; ticks(H + 1);
        bus.power_on_key = 1'b1; bus.power_off_key = 1'b1; ticks(2);
        check("both_ramp", 32'(bus.state), 32'd3);
        bus.power_on_key = 1'b0; bus.power_off_key = 1'b0; ticks(2 * H);

        // On held 100 cycles: one ramp, no restart after shutdown
        bus.power_on_key = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i == 30) bus.power_off_key = 1'b1;
            if (i == 32) bus.power_off_key = 1'b0;
            tick();
        end
        check("held_once", 32'(bus.state), 32'd0);
        press_on(); check("held_repress", 32'(bus.state), 32'd1);
        bus.power_off_key = 1'b1; ticks(4); bus.power_off_key = 1'b0; bus.power_on_key = 1'b0;
        ticks(2);

        // Press while interlock open in OFF
        bus.thermal_ok = 1'b0; press_on(); tick();
        check("cold_on", 32'(bus.state), 32'd0);
        bus.thermal_ok = 1'b1; ticks(2);

        // Asynchronous reset mid-RAMP with the key still held
        press_on(); ticks(H + 2);
        check("arst_pre", 32'(bus.stage_rst_n), 32'b0001);
        #2 rst = 1'b1;
        #1;
        check("arst_state", 32'(bus.state), 32'd0);
        check("arst_outs", {25'd0, bus.stage_rst_n, bus.ready, bus.ind_power, bus.ind_fault}, 32'd0);
        model_reset();
        ticks(2);
        rst = 1'b0; ticks(6);
        check("arst_held_key", 32'(bus.state), 32'd0);
        bus.power_on_key = 1'b0; ticks(2);

        // Randomized phase against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 11) == 0) bus.power_on_key = ~bus.power_on_key;
            if ($urandom_range(0, 29) == 0) bus.power_off_key = ~bus.power_off_key;
            if (bus.thermal_ok) bus.thermal_ok = ($urandom_range(0, 149) != 0);
            else bus.thermal_ok = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
